// File: rtl/lastfrog_pkg.sv
// +--------------------------------------------------------------------------+
// | lastfrog_pkg                                                             |
// | Shared types and constants for the frogger lane logic.                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package lastfrog_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } lane_state_e;

  localparam int DIR_LEFT  = 0;
  localparam int DIR_RIGHT = 1;

  // Fibonacci taps for x^8+x^6+x^5+x^4+1, as bit positions 7,5,4,3
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

`default_nettype wire

// File: rtl/rise_edge_detect.sv
// +--------------------------------------------------------------------------+
// | rise_edge_detect                                                         |
// | Single-cycle pulse on each rising edge of a level synchronous to i_Clk.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module rise_edge_detect (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Sig,
  output logic o_Rise
);

  logic sig_prev_q;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sig_prev_q <= 1'b0;
    end else begin
      sig_prev_q <= i_Sig;
    end
  end

  assign o_Rise = i_Sig & ~sig_prev_q;

endmodule

`default_nettype wire

// File: rtl/lane_scroller.sv
// +--------------------------------------------------------------------------+
// | lane_scroller                                                            |
// | Rotates one obstacle lane on prescaled divider edges, flags collisions.  |
// | Optional macro LANE_SCROLLER_LFSR_EN: LFSR bit replaces the wrapped bit. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module lane_scroller
  import lastfrog_pkg::*;
#(
  parameter int                    LANE_WIDTH   = 16,
  parameter logic [LANE_WIDTH-1:0] INIT_PATTERN = 16'h0F0F,
  parameter int                    DIR          = 0,
  parameter int                    COL_W        = 4
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  input  logic                  i_Step_Clk,
  input  logic                  i_Enable,
  input  logic [3:0]            i_Speed_Div,
  input  logic                  i_Load,
  input  logic [LANE_WIDTH-1:0] i_Load_Pattern,
  input  logic [COL_W-1:0]      i_Frog_Col,
  input  logic                  i_Frog_In_Lane,
  output logic [LANE_WIDTH-1:0] o_Lane,
  output logic                  o_Shift_Pulse,
  output logic                  o_Hit
);

  lane_state_e           state_q, state_d;
  logic [LANE_WIDTH-1:0] lane_q, lane_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  hit_q, hit_d;
  logic                  pulse_q, pulse_d;

  logic                  w_rise;
  logic                  w_fire;
  logic                  w_ins_bit;
  logic                  w_hit_now;
  logic [LANE_WIDTH-1:0] w_rot;

  rise_edge_detect u_step_edge (
    .i_Clk  (i_Clk),
    .i_Rst_L(i_Rst_L),
    .i_Sig  (i_Step_Clk),
    .o_Rise (w_rise)
  );

  // A shift happens only in RUN with enable held, and a load always wins
  assign w_fire = ~i_Load & (state_q == ST_RUN) & i_Enable & w_rise &
                  (cnt_q >= i_Speed_Div);

  assign w_hit_now = i_Frog_In_Lane & (int'(i_Frog_Col) < LANE_WIDTH) &
                     lane_q[i_Frog_Col];

`ifdef LANE_SCROLLER_LFSR_EN
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (i_Load) begin
      lfsr_d = LFSR_SEED;
    end else if (w_fire) begin
      lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign w_ins_bit = lfsr_q[0];
`else
  generate
    if (DIR == DIR_RIGHT) begin : g_wrap_right
      assign w_ins_bit = lane_q[0];
    end else begin : g_wrap_left
      assign w_ins_bit = lane_q[LANE_WIDTH-1];
    end
  endgenerate
`endif

  generate
    if (DIR == DIR_RIGHT) begin : g_rot_right
      assign w_rot = {w_ins_bit, lane_q[LANE_WIDTH-1:1]};
    end else begin : g_rot_left
      assign w_rot = {lane_q[LANE_WIDTH-2:0], w_ins_bit};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    cnt_d   = cnt_q;
    hit_d   = hit_q;
    pulse_d = w_fire;
    if (i_Load) begin
      state_d = ST_IDLE;
      lane_d  = i_Load_Pattern;
      cnt_d   = 4'd0;
      hit_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = 4'd0;
          if (i_Enable) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!i_Enable) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
          end else begin
            if (w_fire) begin
              lane_d = w_rot;
              cnt_d  = 4'd0;
            end else if (w_rise) begin
              cnt_d = cnt_q + 4'd1;
            end
            // Collision uses the pre-rotation lane; a same-cycle shift still completes
            hit_d = w_hit_now;
            if (w_hit_now) state_d = ST_HALT;
          end
        end
        ST_HALT: begin
          hit_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= ST_IDLE;
      lane_q  <= INIT_PATTERN;
      cnt_q   <= 4'd0;
      hit_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      pulse_q <= pulse_d;
    end
  end

  assign o_Lane        = lane_q;
  assign o_Shift_Pulse = pulse_q;
  assign o_Hit         = hit_q;

endmodule

`default_nettype wire

// File: tb/tb_lane_scroller.sv
// +--------------------------------------------------------------------------+
// | tb_lane_scroller                                                         |
// | Directed self-checking bench; a left and a right rotating instance.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_lane_scroller;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        step  = 1'b0;
  logic        en    = 1'b0;
  logic [3:0]  spd   = 4'd0;
  logic        load  = 1'b0;
  logic [15:0] pat   = 16'h0000;
  logic [3:0]  col   = 4'd0;
  logic        inl   = 1'b0;

  logic [15:0] lane, lane_r;
  logic        pulse, pulse_r, hit, hit_r;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;

  lane_scroller #(.LANE_WIDTH(16), .INIT_PATTERN(16'h0F0F), .DIR(0), .COL_W(4)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Step_Clk(step), .i_Enable(en),
    .i_Speed_Div(spd), .i_Load(load), .i_Load_Pattern(pat),
    .i_Frog_Col(col), .i_Frog_In_Lane(inl),
    .o_Lane(lane), .o_Shift_Pulse(pulse), .o_Hit(hit)
  );

  lane_scroller #(.LANE_WIDTH(16), .INIT_PATTERN(16'h0F0F), .DIR(1), .COL_W(4)) dut_r (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Step_Clk(step), .i_Enable(en),
    .i_Speed_Div(spd), .i_Load(load), .i_Load_Pattern(pat),
    .i_Frog_Col(col), .i_Frog_In_Lane(inl),
    .o_Lane(lane_r), .o_Shift_Pulse(pulse_r), .o_Hit(hit_r)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step_edge();
    @(negedge clk) step = 1'b1;
    @(negedge clk) step = 1'b0;
    if (pulse) pulses++;
    @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] p);
    @(negedge clk) begin pat = p; load = 1'b1; end
    @(negedge clk) load = 1'b0;
  endtask

  task automatic test_reset();
    int hi;
    hi = 0;
    #12;
    n_checks++; if (lane !== 16'h0F0F) begin n_fail++; $display("FAIL reset_lane: got %h expected %h", lane, 16'h0F0F); end
    n_checks++; if ({pulse, hit} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b expected 00", {pulse, hit}); end
    n_checks++; if (lane_r !== 16'h0F0F) begin n_fail++; $display("FAIL reset_lane_r: got %h expected %h", lane_r, 16'h0F0F); end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) step = 1'b1;
      @(negedge clk) step = 1'b0;
      if (pulse) hi++;
    end
    @(negedge clk);
    n_checks++; if (lane !== 16'h0F0F) begin n_fail++; $display("FAIL idle_lane: got %h expected %h", lane, 16'h0F0F); end
    n_checks++; if (hi !== 0) begin n_fail++; $display("FAIL idle_pulse: got %0d pulses expected 0", hi); end
  endtask

  task automatic test_single_shift();
    @(negedge clk) begin en = 1'b1; spd = 4'd0; end
    @(negedge clk) step = 1'b1;
    @(negedge clk) begin
      n_checks++; if (lane !== 16'h1E1E) begin n_fail++; $display("FAIL shift_lane: got %h expected %h", lane, 16'h1E1E); end
      n_checks++; if (pulse !== 1'b1) begin n_fail++; $display("FAIL shift_pulse_hi: got %b expected 1", pulse); end
      step = 1'b0;
    end
    @(negedge clk);
    n_checks++; if (pulse !== 1'b0) begin n_fail++; $display("FAIL shift_pulse_lo: got %b expected 0", pulse); end
    n_checks++; if (lane !== 16'h1E1E) begin n_fail++; $display("FAIL shift_hold: got %h expected %h", lane, 16'h1E1E); end
  endtask

  task automatic test_speed_div();
    spd = 4'd2;
    do_load(16'h0F0F);
    pulses = 0;
    step_edge(); step_edge();
    n_checks++; if (lane !== 16'h0F0F || pulses !== 0) begin n_fail++; $display("FAIL div_prescale: got %h/%0d expected 0f0f/0", lane, pulses); end
    step_edge();
    n_checks++; if (lane !== 16'h1E1E || pulses !== 1) begin n_fail++; $display("FAIL div_first: got %h/%0d expected 1e1e/1", lane, pulses); end
    step_edge(); step_edge(); step_edge();
    n_checks++; if (lane !== 16'h3C3C || pulses !== 2) begin n_fail++; $display("FAIL div_six: got %h/%0d expected 3c3c/2", lane, pulses); end
  endtask

  task automatic test_wrap();
    spd = 4'd0;
    do_load(16'h8000);
    step_edge();
    n_checks++; if (lane !== 16'h0001) begin n_fail++; $display("FAIL wrap_left: got %h expected %h", lane, 16'h0001); end
    n_checks++; if (lane_r !== 16'h4000) begin n_fail++; $display("FAIL right_8000: got %h expected %h", lane_r, 16'h4000); end
    do_load(16'h0001);
    step_edge();
    n_checks++; if (lane_r !== 16'h8000) begin n_fail++; $display("FAIL wrap_right: got %h expected %h", lane_r, 16'h8000); end
    n_checks++; if (lane !== 16'h0002) begin n_fail++; $display("FAIL left_0001: got %h expected %h", lane, 16'h0002); end
  endtask

  task automatic test_hit();
    col = 4'd0; inl = 1'b0;
    do_load(16'h0001);
    @(negedge clk) inl = 1'b1;
    @(negedge clk);
    n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL hit_set: got %b expected 1", hit); end
    pulses = 0;
    step_edge(); step_edge();
    n_checks++; if (lane !== 16'h0001 || hit !== 1'b1 || pulses !== 0) begin n_fail++; $display("FAIL halt_frozen: got %h/%b/%0d expected 0001/1/0", lane, hit, pulses); end
    en = 1'b0; inl = 1'b0;
    do_load(16'h00F0);
    n_checks++; if (lane !== 16'h00F0 || hit !== 1'b0) begin n_fail++; $display("FAIL hit_clear: got %h/%b expected 00f0/0", lane, hit); end
    step_edge();
    n_checks++; if (lane !== 16'h00F0) begin n_fail++; $display("FAIL load_idle: got %h expected %h", lane, 16'h00F0); end
  endtask

  task automatic test_hit_boundaries();
    en = 1'b1; col = 4'd0; inl = 1'b0;
    do_load(16'h0001);
    @(negedge clk) begin inl = 1'b1; step = 1'b1; end
    @(negedge clk) begin
      n_checks++; if (lane !== 16'h0002 || hit !== 1'b1 || pulse !== 1'b1) begin n_fail++; $display("FAIL hit_and_edge: got %h/%b/%b expected 0002/1/1", lane, hit, pulse); end
      step = 1'b0; inl = 1'b0;
    end
    en = 1'b0;
    do_load(16'hFFFF);
    @(negedge clk) begin en = 1'b1; inl = 1'b1; col = 4'd7; end
    @(negedge clk);
    n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL ones_idle: got %b expected 0", hit); end
    @(negedge clk);
    n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL ones_hit: got %b expected 1", hit); end
    col = 4'd0;
    do_load(16'h0000);
    pulses = 0;
    step_edge(); step_edge(); step_edge();
    n_checks++; if (lane !== 16'h0000 || hit !== 1'b0 || pulses !== 3) begin n_fail++; $display("FAIL zeros_run: got %h/%b/%0d expected 0000/0/3", lane, hit, pulses); end
    inl = 1'b0;
  endtask

  task automatic test_load_edge();
    do_load(16'h0F0F);
    @(negedge clk) begin pat = 16'h1234; load = 1'b1; step = 1'b1; end
    @(negedge clk) begin
      load = 1'b0;
      n_checks++; if (lane !== 16'h1234 || pulse !== 1'b0) begin n_fail++; $display("FAIL load_vs_edge: got %h/%b expected 1234/0", lane, pulse); end
      n_checks++; if (lane_r !== 16'h1234) begin n_fail++; $display("FAIL load_vs_edge_r: got %h expected 1234", lane_r); end
      step = 1'b0;
    end
  endtask

  task automatic test_reset_mid_run();
    do_load(16'h0F0F);
    step_edge();
    n_checks++; if (lane !== 16'h1E1E) begin n_fail++; $display("FAIL prereset_shift: got %h expected 1e1e", lane); end
    @(negedge clk) step = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (lane !== 16'h0F0F || pulse !== 1'b0 || hit !== 1'b0) begin n_fail++; $display("FAIL async_reset: got %h/%b/%b expected 0f0f/0/0", lane, pulse, hit); end
    @(negedge clk) begin rst_n = 1'b1; step = 1'b0; end
  endtask

  initial begin
    test_reset();
    test_single_shift();
    test_speed_div();
    test_wrap();
    test_hit();
    test_hit_boundaries();
    test_load_edge();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
